// File: rtl/radio_frame_serializer.sv
// Packs NUM_RADIOS I/Q samples into one W-bit word per strobe and shifts it out MSB first,
// inserting a sync word ahead of every WORDS_PER_FRAME data words; a one-word hold absorbs jitter.
module radio_frame_serializer #(
  parameter int unsigned NUM_RADIOS      = 2,
  parameter int unsigned SAMPLE_BITS     = 2,
  parameter int unsigned WORDS_PER_FRAME = 16,
  parameter int unsigned SYNC_PATTERN    = 'hA5
) (
  input  logic                                SYS_CLK,
  input  logic                                RST,
  input  logic                                EN,
  input  logic                                SAMPLE_STB,
  input  logic [NUM_RADIOS*SAMPLE_BITS-1:0]   R_I,
  input  logic [NUM_RADIOS*SAMPLE_BITS-1:0]   R_Q,
  input  logic                                CLR_OVR,
  output logic                                DATA_OUT,
  output logic                                DATA_VALID,
  output logic                                SYNC,
  output logic                                OVERRUN,
  output logic [1:0]                          dbg_state
);

  localparam int unsigned W     = NUM_RADIOS * 2 * SAMPLE_BITS;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;

  localparam logic [W-1:0]     SYNC_WORD = W'(SYNC_PATTERN);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_FRAME - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT_SYNC = 2'd1,
    ST_SHIFT_DATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             sync_sent_q, sync_sent_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             sync_q, sync_d;
  logic             overrun_q, overrun_d;

  logic [W-1:0]     packed_word;
  logic [W-1:0]     load_word;
  logic             word_done, load, load_sync, load_data;
  logic             accept, hold_write, drop;

  // Radio 0 lands in the MSBs; within a radio, I sits above Q.
  for (genvar k = 0; k < NUM_RADIOS; k++) begin : g_pack
    assign packed_word[W-1-(2*k)*SAMPLE_BITS -: SAMPLE_BITS]   = R_I[k*SAMPLE_BITS +: SAMPLE_BITS];
    assign packed_word[W-1-(2*k+1)*SAMPLE_BITS -: SAMPLE_BITS] = R_Q[k*SAMPLE_BITS +: SAMPLE_BITS];
  end

  // Handshake: HOLD accepts a strobe when empty or when its word moves to the shifter on the same edge.
  always_comb begin
    word_done  = (state_q != ST_IDLE) && (bit_cnt_q == LAST_BIT);
    load       = ((state_q == ST_IDLE) || word_done) && hold_full_q;
    load_sync  = load && (word_idx_q == '0) && !sync_sent_q;
    load_data  = load && !load_sync;
    accept     = SAMPLE_STB && EN;
    hold_write = accept && (!hold_full_q || load_data);
    drop       = accept && !hold_write;
    load_word  = load_sync ? SYNC_WORD : hold_q;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    sync_d       = 1'b0;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    word_idx_d   = word_idx_q;
    sync_sent_d  = sync_sent_q;
    overrun_d    = overrun_q;

    if (load) begin
      state_d      = load_sync ? ST_SHIFT_SYNC : ST_SHIFT_DATA;
      bit_cnt_d    = '0;
      data_out_d   = load_word[W-1];
      shreg_d      = load_word << 1;
      data_valid_d = 1'b1;
      sync_d       = load_sync;
    end else if (word_done) begin
      state_d      = ST_IDLE;
      bit_cnt_d    = '0;
      data_out_d   = 1'b0;
      data_valid_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      data_out_d = shreg_q[W-1];
      shreg_d    = shreg_q << 1;
      bit_cnt_d  = bit_cnt_q + 1'b1;
    end

    // Sync leaves HOLD full so its data word follows with no gap.
    if (load_sync) begin
      sync_sent_d = 1'b1;
    end
    if (load_data) begin
      hold_full_d = 1'b0;
      if (word_idx_q == LAST_IDX) begin
        word_idx_d  = '0;
        sync_sent_d = 1'b0;
      end else begin
        word_idx_d = word_idx_q + 1'b1;
      end
    end
    if (hold_write) begin
      hold_d      = packed_word;
      hold_full_d = 1'b1;
    end

    if (drop) begin
      overrun_d = 1'b1;
    end else if (CLR_OVR) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      word_idx_q   <= '0;
      sync_sent_q  <= 1'b0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      sync_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      word_idx_q   <= word_idx_d;
      sync_sent_q  <= sync_sent_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sync_q       <= sync_d;
      overrun_q    <= overrun_d;
    end
  end

  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;
  assign SYNC       = sync_q;
  assign OVERRUN    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_radio_frame_serializer.sv
// Directed bench for radio_frame_serializer: default build plus a 4-radio, 1-bit-sample build
// sharing the same stimulus.
module tb_radio_frame_serializer;

  localparam int W = 8;

  logic       SYS_CLK = 1'b0;
  logic       RST, EN, SAMPLE_STB, CLR_OVR;
  logic [3:0] R_I, R_Q;
  logic       data_out, data_valid, sync, overrun;
  logic       data_out2, data_valid2, sync2, overrun2;
  logic [1:0] dbg_state, dbg_state2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stray_sync = 0;
  int mid_sync   = 0;

  logic cap_bit[$];
  logic cap_sync[$];
  int   cap_cyc[$];
  logic cap2_bit[$];
  logic cap2_sync[$];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic         got_sync_q[$];
  logic [W-1:0] got2_q[$];
  logic         got2_sync_q[$];

  always #5 SYS_CLK = ~SYS_CLK;

  radio_frame_serializer dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .EN(EN), .SAMPLE_STB(SAMPLE_STB),
    .R_I(R_I), .R_Q(R_Q), .CLR_OVR(CLR_OVR),
    .DATA_OUT(data_out), .DATA_VALID(data_valid), .SYNC(sync), .OVERRUN(overrun),
    .dbg_state(dbg_state)
  );

  radio_frame_serializer #(.NUM_RADIOS(4), .SAMPLE_BITS(1)) dut2 (
    .SYS_CLK(SYS_CLK), .RST(RST), .EN(EN), .SAMPLE_STB(SAMPLE_STB),
    .R_I(R_I), .R_Q(R_Q), .CLR_OVR(CLR_OVR),
    .DATA_OUT(data_out2), .DATA_VALID(data_valid2), .SYNC(sync2), .OVERRUN(overrun2),
    .dbg_state(dbg_state2)
  );

  // ---------------- clock / capture ----------------
  task automatic tick();
    @(posedge SYS_CLK);
    #1;
    cyc++;
    if (data_valid === 1'b1) begin
      cap_bit.push_back(data_out);
      cap_sync.push_back(sync);
      cap_cyc.push_back(cyc);
    end else if (sync !== 1'b0) begin
      stray_sync++;
    end
    if (data_valid2 === 1'b1) begin
      cap2_bit.push_back(data_out2);
      cap2_sync.push_back(sync2);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_capture();
    cap_bit.delete(); cap_sync.delete(); cap_cyc.delete();
    cap2_bit.delete(); cap2_sync.delete();
    stray_sync = 0;
  endtask

  // ---------------- drivers ----------------
  // Inverse of the default packing {I0,Q0,I1,Q1}: chooses R_I/R_Q that pack to w.
  task automatic drive_word(input logic [7:0] w);
    R_I = {w[3:2], w[7:6]};
    R_Q = {w[1:0], w[5:4]};
  endtask

  task automatic strobe_word(input logic [7:0] w, input logic clr);
    drive_word(w);
    SAMPLE_STB = 1'b1;
    CLR_OVR    = clr;
    tick();
    SAMPLE_STB = 1'b0;
    CLR_OVR    = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; SAMPLE_STB = 1'b0; CLR_OVR = 1'b0;
    tick();
    RST = 1'b0;
    clear_capture();
  endtask

  task automatic build_words();
    got_q.delete(); got_sync_q.delete(); got2_q.delete(); got2_sync_q.delete();
    mid_sync = 0;
    for (int i = 0; i + W <= cap_bit.size(); i += W) begin
      logic [W-1:0] w;
      w = '0;
      for (int b = 0; b < W; b++) begin
        w = {w[W-2:0], cap_bit[i+b]};
        if (b != 0 && cap_sync[i+b]) mid_sync++;
      end
      got_q.push_back(w);
      got_sync_q.push_back(cap_sync[i]);
    end
    for (int i = 0; i + W <= cap2_bit.size(); i += W) begin
      logic [W-1:0] w;
      w = '0;
      for (int b = 0; b < W; b++) w = {w[W-2:0], cap2_bit[i+b]};
      got2_q.push_back(w);
      got2_sync_q.push_back(cap2_sync[i]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      EN = 1'($urandom_range(0, 1)); SAMPLE_STB = 1'($urandom_range(0, 1));
      CLR_OVR = 1'($urandom_range(0, 1));
      R_I = 4'($urandom_range(0, 15)); R_Q = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if ({data_out, data_valid, sync, overrun, data_out2, data_valid2, sync2, overrun2} !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: outputs=%b expected=00000000", i,
                 {data_out, data_valid, sync, overrun, data_out2, data_valid2, sync2, overrun2});
      end
    end
    RST = 1'b0; SAMPLE_STB = 1'b0; CLR_OVR = 1'b0; EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({data_out, data_valid, sync, overrun, data_out2, data_valid2, sync2, overrun2} !== 8'h00) begin
        failures++;
        $display("FAIL reset_release cycle %0d: outputs=%b expected=00000000", i,
                 {data_out, data_valid, sync, overrun, data_out2, data_valid2, sync2, overrun2});
      end
    end
  endtask

  task automatic test_single_word();
    logic [15:0] seq, sseq;
    int stb_cyc, first, last;
    do_reset();
    EN = 1'b1;
    strobe_word(8'hC9, 1'b0);
    stb_cyc = cyc;
    idle(20);
    seq = '0; sseq = '0;
    for (int i = 0; i < 16; i++) begin
      seq  = {seq[14:0],  (i < cap_bit.size())  ? cap_bit[i]  : 1'bx};
      sseq = {sseq[14:0], (i < cap_sync.size()) ? cap_sync[i] : 1'bx};
    end
    first = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
    last  = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -1;
    checks++;
    if (cap_bit.size() != 16) begin
      failures++; $display("FAIL single_bit_count: got %0d expected 16", cap_bit.size());
    end
    checks++;
    if (seq !== 16'hA5C9) begin
      failures++; $display("FAIL single_bits: got %h expected a5c9", seq);
    end
    checks++;
    if (sseq !== 16'h8000 || stray_sync != 0) begin
      failures++; $display("FAIL single_sync: got %h stray=%0d expected 8000 stray=0", sseq, stray_sync);
    end
    checks++;
    if (first != stb_cyc + 1) begin
      failures++; $display("FAIL single_latency: first valid cycle %0d expected %0d", first, stb_cyc + 1);
    end
    checks++;
    if (last - first != 15) begin
      failures++; $display("FAIL single_contiguous: span %0d expected 15", last - first);
    end
    checks++;
    if (data_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL single_after: valid=%b overrun=%b expected 0 0", data_valid, overrun);
    end
  endtask

  task automatic test_enable_low();
    do_reset();
    EN = 1'b0;
    strobe_word(8'h3C, 1'b0);
    idle(20);
    checks++;
    if (cap_bit.size() != 0) begin
      failures++; $display("FAIL enable_low: got %0d valid bits expected 0", cap_bit.size());
    end
    EN = 1'b1;
  endtask

  task automatic test_frame_sequence();
    logic [7:0] w;
    do_reset();
    EN = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      w = 8'(i * 37 + 11);
      if (i == 0 || i == 16) exp_q.push_back(8'hA5);
      exp_q.push_back(w);
      strobe_word(w, 1'b0);
      idle(8);
    end
    idle(30);
    build_words();
    checks++;
    if (cap_bit.size() != 34 * W) begin
      failures++; $display("FAIL frame_bit_count: got %0d expected %0d", cap_bit.size(), 34 * W);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [W-1:0] g;
      logic gs, es;
      g  = (i < got_q.size()) ? got_q[i] : 'x;
      gs = (i < got_sync_q.size()) ? got_sync_q[i] : 1'bx;
      es = (i == 0 || i == 17);
      checks++;
      if (g !== exp_q[i]) begin
        failures++; $display("FAIL frame_word[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
      checks++;
      if (gs !== es) begin
        failures++; $display("FAIL frame_sync[%0d]: got %b expected %b", i, gs, es);
      end
    end
    checks++;
    if (mid_sync != 0 || stray_sync != 0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL frame_clean: mid_sync=%0d stray=%0d overrun=%b expected 0 0 0", mid_sync, stray_sync, overrun);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] words [8];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    EN = 1'b1;
    exp_q.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h11); exp_q.push_back(8'h44);
    exp_q.push_back(8'h66); exp_q.push_back(8'h88);
    for (int i = 0; i < 8; i++) begin
      strobe_word(words[i], 1'b0);
      if (i == 0) begin
        checks++;
        if (overrun !== 1'b0) begin
          failures++; $display("FAIL ovr_before_drop: got %b expected 0", overrun);
        end
      end
      if (i == 1) begin
        checks++;
        if (overrun !== 1'b1) begin
          failures++; $display("FAIL ovr_first_drop: got %b expected 1", overrun);
        end
      end
      idle(3);
    end
    idle(40);
    build_words();
    checks++;
    if (got_q.size() != 5) begin
      failures++; $display("FAIL ovr_word_count: got %0d expected 5", got_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] g;
      logic gs;
      g  = (i < got_q.size()) ? got_q[i] : 'x;
      gs = (i < got_sync_q.size()) ? got_sync_q[i] : 1'bx;
      checks++;
      if (g !== exp_q[i] || gs !== (i == 0)) begin
        failures++; $display("FAIL ovr_word[%0d]: got %h sync=%b expected %h sync=%b", i, g, gs, exp_q[i], i == 0);
      end
    end
    CLR_OVR = 1'b1;
    tick();
    CLR_OVR = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL ovr_clear: got %b expected 0", overrun);
    end
    clear_capture();
    strobe_word(8'h5A, 1'b0);
    idle(1);
    strobe_word(8'hC3, 1'b0);
    idle(1);
    strobe_word(8'hF0, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_set_wins: got %b expected 1", overrun);
    end
    idle(25);
    build_words();
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'h5A || got_q[1] !== 8'hC3 || got_sync_q[0] !== 1'b0) begin
      failures++;
      $display("FAIL ovr_tail_words: got count=%0d first=%h second=%h expected count=2 5a c3 no sync",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, (got_q.size() > 1) ? got_q[1] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int stb_cyc, first, last;
    do_reset();
    EN = 1'b1;
    strobe_word(8'h96, 1'b0);
    stb_cyc = cyc;
    idle(8);
    strobe_word(8'h3D, 1'b0);
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL b2b_no_overrun: got %b expected 0", overrun);
    end
    idle(25);
    build_words();
    first = (cap_cyc.size() > 0) ? cap_cyc[0] : -1;
    last  = (cap_cyc.size() > 0) ? cap_cyc[cap_cyc.size()-1] : -1;
    checks++;
    if (got_q.size() != 3 || got_q[0] !== 8'hA5 || got_q[1] !== 8'h96 || got_q[2] !== 8'h3D) begin
      failures++;
      $display("FAIL b2b_words: got count=%0d words=%p expected a5 96 3d", got_q.size(), got_q);
    end
    checks++;
    if (cap_bit.size() != 24 || first != stb_cyc + 1 || last - first != 23) begin
      failures++;
      $display("FAIL b2b_gapless: bits=%0d first=%0d span=%0d expected 24 %0d 23",
               cap_bit.size(), first, last - first, stb_cyc + 1);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [11:0] part;
    do_reset();
    EN = 1'b1;
    strobe_word(8'hE7, 1'b0);
    idle(12);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({data_out, data_valid, sync, overrun, data_out2, data_valid2, sync2, overrun2} !== 8'h00) begin
      failures++;
      $display("FAIL midrst_outputs: got %b expected 00000000",
               {data_out, data_valid, sync, overrun, data_out2, data_valid2, sync2, overrun2});
    end
    part = '0;
    for (int i = 0; i < 12; i++) part = {part[10:0], (i < cap_bit.size()) ? cap_bit[i] : 1'bx};
    checks++;
    if (cap_bit.size() != 12 || part !== 12'hA5E) begin
      failures++; $display("FAIL midrst_partial: bits=%0d value=%h expected 12 a5e", cap_bit.size(), part);
    end
    idle(3);
    checks++;
    if (cap_bit.size() != 12 || data_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_quiet: bits=%0d valid=%b expected 12 0", cap_bit.size(), data_valid);
    end
    clear_capture();
    strobe_word(8'hC9, 1'b0);
    idle(20);
    build_words();
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 8'hA5 || got_q[1] !== 8'hC9 ||
        got_sync_q[0] !== 1'b1 || got_sync_q[1] !== 1'b0) begin
      failures++; $display("FAIL midrst_resync: got count=%0d words=%p expected a5(sync) c9", got_q.size(), got_q);
    end
    checks++;
    if (got2_q.size() != 2 || got2_q[0] !== 8'hA5 || got2_q[1] !== 8'hA6 ||
        got2_sync_q[0] !== 1'b1 || got2_sync_q[1] !== 1'b0) begin
      failures++; $display("FAIL pack_4x1: got count=%0d words=%p expected a5(sync) a6", got2_q.size(), got2_q);
    end
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; SAMPLE_STB = 1'b0; CLR_OVR = 1'b0;
    R_I = '0; R_Q = '0;
    test_reset();
    test_single_word();
    test_enable_low();
    test_frame_sequence();
    test_overrun();
    test_back_to_back();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
